instr_stream_fetch: RTL and testbench

- Upstream feeder for the `solve` instruction classifier/counter stage.
- Holds a small loadable MIPS instruction store and a fetch pointer.
- On `start`, streams the stored 32-bit instructions in order over a valid/ready handshake, one word per accepted transfer, then flags completion.
- Lets the downstream counter run back-to-back programs without a bench-driven instruction bus.

---
 rtl/instr_stream_pkg.sv | 14 +
 rtl/instr_store.sv | 26 ++
 rtl/instr_stream_fetch.sv | 144 ++++++++++++++
 tb/tb_instr_stream_fetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_stream_pkg.sv
// rtl/instr_stream_pkg.sv - Shared types and constants for the instruction stream fetcher
package instr_stream_pkg;

   localparam int DW_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_store.sv
// rtl/instr_store.sv - Instruction word register array, one write port and one combinational read port
module instr_store #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   // Contents deliberately survive reset so a loaded program can be rerun.
   logic [DW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_stream_fetch.sv
// rtl/instr_stream_fetch.sv - Streams a loaded instruction store over valid/ready to the solve stage
// Optional INSTR_HALT_DETECT_EN: the stream ends at the first HALT_WORD, which is never presented.
module instr_stream_fetch
   import instr_stream_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int DW    = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic [AW:0]   n_instr,
   input  logic          start,
   output logic [DW-1:0] instr_out,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [AW:0]   sent_cnt,
   output logic          busy,
   output logic          done
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   state_t        r_state, w_state_nxt;
   logic [AW:0]   r_limit, w_limit_nxt;
   logic [AW:0]   r_sent, w_sent_nxt;
   logic [AW-1:0] r_ptr, w_ptr_nxt;
   logic [DW-1:0] r_out, w_out_nxt;
   logic          r_valid, w_valid_nxt;
   logic          r_done, w_done_nxt;

   logic          w_idle_like;
   logic          w_ld_acc;
   logic          w_start_acc;
   logic          w_hs;
   logic          w_rd_is_halt;
   logic [AW-1:0] w_rd_addr;
   logic [DW-1:0] w_rd_data;
   logic [AW:0]   w_n_clamp;
   logic [AW:0]   w_sent_inc;

   assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
   assign w_ld_acc    = ld_en && w_idle_like;
   assign w_start_acc = start && w_idle_like && !ld_en;
   assign w_hs        = (r_state == RUN) && r_valid && instr_ready;
   assign w_n_clamp   = (n_instr > LP_DEPTH) ? LP_DEPTH : n_instr;
   assign w_sent_inc  = r_sent + (AW+1)'(1);
   // Outside RUN the read port looks at word 0 so a start can launch it directly.
   assign w_rd_addr   = w_idle_like ? '0 : r_ptr;

   instr_store #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_store (
      .clk     (clk),
      .i_we    (w_ld_acc),
      .i_waddr (ld_addr),
      .i_wdata (ld_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_data)
   );

`ifdef INSTR_HALT_DETECT_EN
   assign w_rd_is_halt = (w_rd_data == DW'(HALT_WORD));
`else
   assign w_rd_is_halt = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_limit <= '0;
         r_sent  <= '0;
         r_ptr   <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_limit <= w_limit_nxt;
         r_sent  <= w_sent_nxt;
         r_ptr   <= w_ptr_nxt;
         r_out   <= w_out_nxt;
         r_valid <= w_valid_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_limit_nxt = r_limit;
      w_sent_nxt  = r_sent;
      w_ptr_nxt   = r_ptr;
      w_out_nxt   = r_out;
      w_valid_nxt = r_valid;
      w_done_nxt  = r_done;
      case (r_state)
         IDLE, DONE: begin
            if (w_start_acc) begin
               w_sent_nxt  = '0;
               w_limit_nxt = w_n_clamp;
               if ((w_n_clamp == '0) || w_rd_is_halt) begin
                  w_state_nxt = DONE;
                  w_valid_nxt = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = RUN;
                  w_out_nxt   = w_rd_data;
                  w_valid_nxt = 1'b1;
                  w_ptr_nxt   = AW'(1);
                  w_done_nxt  = 1'b0;
               end
            end
         end
         RUN: begin
            if (w_hs) begin
               w_sent_nxt = w_sent_inc;
               if ((w_sent_inc < r_limit) && !w_rd_is_halt) begin
                  w_out_nxt = w_rd_data;
                  w_ptr_nxt = r_ptr + AW'(1);
               end else begin
                  w_state_nxt = DONE;
                  w_valid_nxt = 1'b0;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign instr_out   = r_out;
   assign instr_valid = r_valid;
   assign sent_cnt    = r_sent;
   assign busy        = (r_state == RUN);
   assign done        = r_done;

endmodule

// File: tb/tb_instr_stream_fetch.sv
// tb/tb_instr_stream_fetch.sv - Directed table-driven bench for instr_stream_fetch
module tb_instr_stream_fetch;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic [AW:0]   n_instr;
   logic          start;
   logic [DW-1:0] instr_out;
   logic          instr_valid;
   logic          instr_ready;
   logic [AW:0]   sent_cnt;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] model [DEPTH];

   typedef struct {
      logic [AW:0] n;
      logic [15:0] pat;
      int          exp_words;
      int          exp_cycles;
   } vec_t;

   vec_t vecs [7];

   instr_stream_fetch #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .ld_en       (ld_en),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .n_instr     (n_instr),
      .start       (start),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .sent_cnt    (sent_cnt),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int addr, input logic [DW-1:0] data);
      ld_en   = 1'b1;
      ld_addr = AW'(addr);
      ld_data = data;
      tick();
      ld_en = 1'b0;
      model[addr] = data;
   endtask

   task automatic stream(input string tag, input logic [AW:0] n, input logic [15:0] pat,
                         input int exp_words, input int exp_cycles);
      int got = 0;
      int cyc = 0;
      int pi  = 0;
      logic          hold_pend = 1'b0;
      logic [DW-1:0] held = '0;
      instr_ready = 1'b0;
      n_instr = n;
      start   = 1'b1;
      tick();
      start = 1'b0;
      check({tag, " first_valid"}, instr_valid, exp_words > 0);
      while (!done && cyc < 200) begin
         check({tag, " sent_cnt_live"}, sent_cnt, got);
         if (hold_pend) begin
            check({tag, " hold_word"}, instr_out, held);
            check({tag, " hold_valid"}, instr_valid, 1'b1);
         end
         instr_ready = pat[pi % 16];
         pi++;
         if (instr_valid) begin
            if (instr_ready) begin
               if (got < DEPTH) check({tag, " word"}, instr_out, model[got]);
               else             check({tag, " overrun"}, got, DEPTH - 1);
               got++;
               hold_pend = 1'b0;
            end else begin
               held      = instr_out;
               hold_pend = 1'b1;
            end
         end
         tick();
         cyc++;
      end
      instr_ready = 1'b0;
      check({tag, " done"}, done, 1'b1);
      check({tag, " words"}, got, exp_words);
      check({tag, " sent_cnt"}, sent_cnt, exp_words);
      check({tag, " busy_end"}, busy, 1'b0);
      check({tag, " valid_end"}, instr_valid, 1'b0);
      if (exp_cycles >= 0) check({tag, " cycles"}, cyc, exp_cycles);
   endtask

   initial begin
      rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      n_instr = '0; start = 1'b0; instr_ready = 1'b0;

      vecs[0] = '{n: 4'd4,  pat: 16'hFFFF, exp_words: 4, exp_cycles: 4};
      vecs[1] = '{n: 4'd4,  pat: 16'h9999, exp_words: 4, exp_cycles: -1};
      vecs[2] = '{n: 4'd0,  pat: 16'hFFFF, exp_words: 0, exp_cycles: 0};
      vecs[3] = '{n: 4'd1,  pat: 16'hFFFF, exp_words: 1, exp_cycles: 1};
      vecs[4] = '{n: 4'd8,  pat: 16'h5555, exp_words: 8, exp_cycles: 15};
      vecs[5] = '{n: 4'd12, pat: 16'hFFFF, exp_words: 8, exp_cycles: 8};
      vecs[6] = '{n: 4'd15, pat: 16'hAAAA, exp_words: 8, exp_cycles: 16};

      tick();
      tick();
      check("reset instr_out", instr_out, 32'h0);
      check("reset instr_valid", instr_valid, 1'b0);
      check("reset sent_cnt", sent_cnt, 4'd0);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      rst = 1'b0;
      tick();

      load(0, 32'h0043_2020);
      load(1, 32'h2005_0007);
      load(2, 32'h0800_0010);
      load(3, 32'h0086_3022);
      load(4, 32'h8C88_0004);
      load(5, 32'hAC89_0008);
      load(6, 32'h1109_0003);
      load(7, 32'h3C0A_1234);
      check("idle after load", busy, 1'b0);

      for (int i = 0; i < 7; i++) begin
         stream($sformatf("vec%0d", i), vecs[i].n, vecs[i].pat, vecs[i].exp_words, vecs[i].exp_cycles);
      end

      // Reset while the second word is on the bus.
      n_instr = 4'd4;
      start   = 1'b1;
      tick();
      start       = 1'b0;
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("midrst second word", instr_out, model[1]);
      check("midrst busy before", busy, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("midrst valid", instr_valid, 1'b0);
      check("midrst busy", busy, 1'b0);
      check("midrst done", done, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      stream("after_rst", 4'd2, 16'hFFFF, 2, 2);

      // Load wins over start in the same cycle.
      ld_en   = 1'b1;
      ld_addr = 3'd5;
      ld_data = 32'h0128_5825;
      n_instr = 4'd4;
      start   = 1'b1;
      tick();
      ld_en = 1'b0;
      start = 1'b0;
      model[5] = 32'h0128_5825;
      check("ld+start valid", instr_valid, 1'b0);
      check("ld+start busy", busy, 1'b0);
      check("ld+start sent_cnt kept", sent_cnt, 4'd2);
      tick();
      check("ld+start still idle", busy, 1'b0);

      // Load attempt during RUN must be dropped.
      n_instr = 4'd8;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      ld_en   = 1'b1;
      ld_addr = 3'd6;
      ld_data = 32'hDEAD_BEEF;
      tick();
      ld_en = 1'b0;
      check("run ld busy", busy, 1'b1);
      check("run ld held word", instr_out, model[0]);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      stream("verify_mem", 4'd8, 16'hFFFF, 8, 8);

      load(2, 32'hFFFF_FFFF);
`ifdef INSTR_HALT_DETECT_EN
      stream("halt_mid", 4'd8, 16'hFFFF, 2, 2);
`else
      stream("halt_mid", 4'd8, 16'hFFFF, 8, 8);
`endif
      load(0, 32'hFFFF_FFFF);
`ifdef INSTR_HALT_DETECT_EN
      stream("halt_first", 4'd4, 16'hFFFF, 0, 0);
`else
      stream("halt_first", 4'd4, 16'hFFFF, 4, 4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
